// File: rtl/count_sequence_checker.sv
// Watches an upstream counter's sampled value and checks that it increments by one and wraps.
// Optional build macro CHECKER_DISPLAY_EN adds simulation messages; port behaviour is unchanged.
module count_sequence_checker #(
  parameter int WIDTH             = 4,
  parameter int ROLLOVERS_TO_DONE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             count_valid,
  output logic             mismatch,
  output logic             halfway,
  output logic             error,
  output logic [7:0]       error_count,
  output logic [7:0]       rollover_count,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] HALF     = WIDTH'(1) << (WIDTH - 1);
  localparam logic [7:0]       DONE_CNT = 8'(ROLLOVERS_TO_DONE);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             mismatch_q, mismatch_d;
  logic             halfway_q, halfway_d;
  logic             error_q, error_d;
  logic [7:0]       error_count_q, error_count_d;
  logic [7:0]       rollover_count_q, rollover_count_d;
  logic             done_q, done_d;

  logic             track_sample;
  logic             is_match;
  logic             wrap;
  logic             reach_done;
  logic [WIDTH-1:0] count_inc;
  logic [7:0]       rollover_inc;

  // A wrap only counts when the 0 was actually expected; a mismatching 0 is just an error.
  always_comb begin
    track_sample = count_valid && (state_q == TRACK);
    is_match     = (count == expected_q);
    count_inc    = count + WIDTH'(1);
    wrap         = track_sample && is_match && (count == '0);
    rollover_inc = rollover_count_q + 8'd1;
    reach_done   = wrap && (rollover_inc == DONE_CNT);
  end

  // State register and all output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      expected_q       <= '0;
      mismatch_q       <= 1'b0;
      halfway_q        <= 1'b0;
      error_q          <= 1'b0;
      error_count_q    <= '0;
      rollover_count_q <= '0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      expected_q       <= expected_d;
      mismatch_q       <= mismatch_d;
      halfway_q        <= halfway_d;
      error_q          <= error_d;
      error_count_q    <= error_count_d;
      rollover_count_q <= rollover_count_d;
      done_q           <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_valid) state_d = TRACK;
      TRACK:   if (reach_done)  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic; pulses default low so they last a single cycle
  always_comb begin
    expected_d       = expected_q;
    mismatch_d       = 1'b0;
    halfway_d        = 1'b0;
    error_d          = error_q;
    error_count_d    = error_count_q;
    rollover_count_d = rollover_count_q;
    done_d           = done_q;
    unique case (state_q)
      IDLE: begin
        if (count_valid) expected_d = count_inc;
      end
      TRACK: begin
        if (count_valid) begin
          expected_d = count_inc;
          if (is_match) begin
            halfway_d = (count == HALF);
            if (wrap)       rollover_count_d = rollover_inc;
            if (reach_done) done_d = 1'b1;
          end else begin
            mismatch_d = 1'b1;
            error_d    = 1'b1;
            if (error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign mismatch       = mismatch_q;
  assign halfway        = halfway_q;
  assign error          = error_q;
  assign error_count    = error_count_q;
  assign rollover_count = rollover_count_q;
  assign done           = done_q;
  assign state          = state_q;

`ifdef CHECKER_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mismatch_d) $display("Mismatch: got %d expected %d", count, expected_q);
      if (halfway_d)  $display("Halfway point reached!");
      if (state_q != DONE && state_d == DONE) begin
        $display("Checker done, errors: %d", error_count_d);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker (WIDTH=4, ROLLOVERS_TO_DONE=1) with a table plus loops.
module tb_count_sequence_checker;

  typedef struct packed {
    logic       mm;
    logic       hw;
    logic       er;
    logic [7:0] ec;
    logic [7:0] rc;
    logic       dn;
    logic [1:0] st;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       valid;
    logic [3:0] count;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = '0;
  logic       count_valid = 1'b0;
  logic       mismatch, halfway, error, done;
  logic [7:0] error_count, rollover_count;
  logic [1:0] state;

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];
  vec_t tbl[$];

  count_sequence_checker #(.WIDTH(4), .ROLLOVERS_TO_DONE(1)) dut (
    .clk(clk), .rst(rst), .count(count), .count_valid(count_valid),
    .mismatch(mismatch), .halfway(halfway), .error(error),
    .error_count(error_count), .rollover_count(rollover_count),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic mm, input logic hw, input logic er,
                              input int ec, input int rc, input logic dn, input int st);
    out_t o;
    o.mm = mm; o.hw = hw; o.er = er;
    o.ec = 8'(ec); o.rc = 8'(rc); o.dn = dn; o.st = 2'(st);
    return o;
  endfunction

  task automatic add(input string name, input logic r, input logic v, input int c, input out_t e);
    vec_t t;
    t.name = name; t.rst = r; t.valid = v; t.count = 4'(c); t.exp = e;
    tbl.push_back(t);
  endtask

  // Drive one cycle, queue its expectation, then score the registered result after the edge.
  task automatic apply(input string name, input logic r, input logic v, input logic [3:0] c,
                       input out_t e);
    out_t got, want;
    @(negedge clk);
    rst = r; count_valid = v; count = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {mismatch, halfway, error, error_count, rollover_count, done, state};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got mm=%b hw=%b err=%b ec=%0d rc=%0d done=%b st=%0d, expected mm=%b hw=%b err=%b ec=%0d rc=%0d done=%b st=%0d",
                 name, got.mm, got.hw, got.er, got.ec, got.rc, got.dn, got.st,
                 want.mm, want.hw, want.er, want.ec, want.rc, want.dn, want.st);
      end
    end
  endtask

  initial begin
    // Skip sequence with a single mismatch
    add("reset",       1, 0, 0, mk(0,0,0,0,0,0,0));
    add("skip_s3",     0, 1, 3, mk(0,0,0,0,0,0,1));
    add("skip_s4",     0, 1, 4, mk(0,0,0,0,0,0,1));
    add("skip_s6",     0, 1, 6, mk(1,0,1,1,0,0,1));
    add("skip_s7",     0, 1, 7, mk(0,0,1,1,0,0,1));
    // Valid gap holds expected; count ignored while invalid
    add("gap_rst",     1, 0, 0, mk(0,0,0,0,0,0,0));
    add("gap_s5",      0, 1, 5, mk(0,0,0,0,0,0,1));
    add("gap_idle1",   0, 0, 12, mk(0,0,0,0,0,0,1));
    add("gap_idle2",   0, 0, 2, mk(0,0,0,0,0,0,1));
    add("gap_idle3",   0, 0, 9, mk(0,0,0,0,0,0,1));
    add("gap_s6",      0, 1, 6, mk(0,0,0,0,0,0,1));
    // Mismatching zero is an error, not a rollover
    add("bad0",        0, 1, 0, mk(1,0,1,1,0,0,1));
    add("after_bad0",  0, 1, 1, mk(0,0,1,1,0,0,1));
    // Mid-TRACK reset, with rst beating a simultaneous sample
    add("mid_rst",     1, 0, 0, mk(0,0,0,0,0,0,0));
    add("mid_s9",      0, 1, 9, mk(0,0,0,0,0,0,1));
    add("mid_s10",     0, 1, 10, mk(0,0,0,0,0,0,1));
    add("rst_wins",    1, 1, 11, mk(0,0,0,0,0,0,0));
    add("post_rst_s5", 0, 1, 5, mk(0,0,0,0,0,0,1));
    add("post_rst_s7", 0, 1, 7, mk(1,0,1,1,0,0,1));

    foreach (tbl[i]) apply(tbl[i].name, tbl[i].rst, tbl[i].valid, tbl[i].count, tbl[i].exp);

    // Full sweep 0..15 then wrap to 0 reaches DONE
    apply("sweep_rst", 1, 0, 4'd0, mk(0,0,0,0,0,0,0));
    for (int i = 0; i < 16; i++)
      apply($sformatf("sweep_%0d", i), 0, 1, 4'(i), mk(0, (i == 8), 0, 0, 0, 0, 1));
    apply("sweep_wrap",  0, 1, 4'd0, mk(0,0,0,0,1,1,2));
    apply("done_hold3",  0, 1, 4'd3, mk(0,0,0,0,1,1,2));
    apply("done_hold9",  0, 1, 4'd9, mk(0,0,0,0,1,1,2));
    apply("done_idle",   0, 0, 4'd1, mk(0,0,0,0,1,1,2));
    apply("done_rst",    1, 0, 4'd0, mk(0,0,0,0,0,0,0));

    // Saturation: constant 9 mismatches on every sample after the first
    apply("sat_first", 0, 1, 4'd9, mk(0,0,0,0,0,0,1));
    for (int k = 1; k <= 300; k++)
      apply($sformatf("sat_%0d", k), 0, 1, 4'd9, mk(1, 0, 1, (k > 255) ? 255 : k, 0, 0, 1));
    apply("sat_match", 0, 1, 4'd10, mk(0,0,1,255,0,0,1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and rst SHALL be the first two ports.
REQ-002 Parameter WIDTH, default 4, SHALL set the width of the monitored count.
REQ-003 Parameter ROLLOVERS_TO_DONE, default 1, range 1..255, SHALL set the number of rollovers that ends the check.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port count, input, WIDTH, sampled counter value from the upstream counter.
REQ-007 Port count_valid, input, 1, count is sampled only when this is 1.
REQ-008 Port mismatch, output, 1, one-cycle pulse when a sample differs from the expected value.
REQ-009 Port halfway, output, 1, one-cycle pulse on a matching sample equal to 2^(WIDTH-1).
REQ-010 Port error, output, 1, sticky flag, set on any mismatch.
REQ-011 Port error_count, output, 8, number of mismatches, saturating at 255.
REQ-012 Port rollover_count, output, 8, number of matching wraps from all-ones to 0.
REQ-013 Port done, output, 1, level, 1 once ROLLOVERS_TO_DONE rollovers have been seen.
REQ-014 Port state, output, 2, current FSM state: IDLE=0, TRACK=1, DONE=2.

Function
REQ-015 All outputs SHALL be registered; a sample at edge N SHALL be reflected on the outputs after edge N.
REQ-016 In IDLE, with count_valid=1: the block SHALL load expected to count+1 mod 2^WIDTH, go to TRACK, and perform no compare.
REQ-017 In TRACK, with count_valid=1 and count==expected: the block SHALL set expected to count+1 mod 2^WIDTH.
REQ-018 In TRACK, with count_valid=1 and count!=expected: the block SHALL
- pulse mismatch,
- set error,
- increment error_count (saturating),
- resynchronise expected to count+1.
REQ-019 A matching sample with count==0 SHALL increment rollover_count; a mismatching 0 SHALL NOT.
REQ-020 When rollover_count reaches ROLLOVERS_TO_DONE, the FSM SHALL move to DONE and assert done in the same cycle rollover_count updates.
REQ-021 A matching sample equal to 2^(WIDTH-1) SHALL pulse halfway.
REQ-022 When count_valid=0, the block SHALL hold all state, and mismatch and halfway SHALL be 0.
REQ-023 In DONE, the block SHALL ignore count and count_valid and hold all outputs until rst.
REQ-024 Once error_count is 255, further mismatches SHALL still pulse mismatch but SHALL leave error_count at 255.
REQ-025 The mismatch and halfway pulses SHALL be mutually exclusive.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL go to IDLE and clear expected and every output to 0; this SHALL include mid-TRACK and DONE.
REQ-027 If rst and count_valid are both 1 at the same edge, rst SHALL win and the sample SHALL be discarded.

Configuration
REQ-028 Macro CHECKER_DISPLAY_EN.
- Defined: on each mismatch, $display "Mismatch: got %d expected %d"; on halfway, $display "Halfway point reached!"; on entry to DONE, $display "Checker done, errors: %d" followed by $finish.
- Undefined: no system tasks are present and the block is fully synthesizable; port behaviour is identical in both cases.

Verification
REQ-029 The bench SHALL cover the following directed scenarios (WIDTH=4, ROLLOVERS_TO_DONE=1):
- Reset, then count 0..15 then 0 with valid every cycle -> halfway pulses after sample 8; rollover_count=1, done=1, state=2, error=0.
- Sequence 3,4,6,7 -> single mismatch after sample 6; error=1, error_count=1; no mismatch on 7.
- Sequence 5, valid low for 3 cycles, then 6 -> no mismatch; expected holds across the gap.
- 300 consecutive mismatching samples (constant 9) -> error_count=255; mismatch still pulses on every sample.
- rst asserted mid-TRACK at count=10 -> next-cycle outputs all 0, state=0; the next sample does no compare.
- In DONE, apply count=3 valid -> no output change.
